// File: rtl/sbox_stream_if.sv
// Handshake bundle for sbox_stream: input beat channel, output result channel and busy.
// The slave modport is the substitution unit. The master modport is the upstream/downstream side.
interface sbox_stream_if #(
    parameter int LANES = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [LANES*8-1:0] in_data;
    logic               in_inv;
    logic               out_valid;
    logic               out_ready;
    logic [LANES*8-1:0] out_data;
    logic               busy;

    modport slave (
        input  in_valid, in_data, in_inv, out_ready,
        output in_ready, out_valid, out_data, busy
    );

    modport master (
        output in_valid, in_data, in_inv, out_ready,
        input  in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/sbox_stream.sv
// Two-stage AES S-box unit: LANES independent byte lookups per beat with valid/ready on both sides.
// Optional macro SBOX_INV_EN adds the inverse table, which is selected per beat by in_inv.
module sbox_stream #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    sbox_stream_if.slave bus
);
    localparam int W = LANES * 8;

    localparam logic [0:255][7:0] FWD_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

`ifdef SBOX_INV_EN
    localparam logic [0:255][7:0] INV_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [W-1:0] sub_word(input logic [W-1:0] d, input logic inv);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            r[8*i +: 8] = inv ? INV_TBL[d[8*i +: 8]] : FWD_TBL[d[8*i +: 8]];
        end
        return r;
    endfunction
`else
    function automatic logic [W-1:0] sub_word(input logic [W-1:0] d);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            r[8*i +: 8] = FWD_TBL[d[8*i +: 8]];
        end
        return r;
    endfunction
`endif

    logic         r_vld_p1;
    logic [W-1:0] r_data_p1;
    logic         r_vld_p2;
    logic [W-1:0] r_data_p2;
    logic         w_adv_p2;
    logic         w_in_rdy;
    logic         w_in_xfer;
    logic [W-1:0] w_sub_p1;

    // in_ready depends combinationally on out_ready, so a full pipe can refill in the drain cycle
    assign w_adv_p2  = !r_vld_p2 || bus.out_ready;
    assign w_in_rdy  = !r_vld_p1 || w_adv_p2;
    assign w_in_xfer = bus.in_valid && w_in_rdy;

`ifdef SBOX_INV_EN
    logic r_inv_p1;
    assign w_sub_p1 = sub_word(r_data_p1, r_inv_p1);
`else
    logic w_unused_inv;
    assign w_unused_inv = bus.in_inv;
    assign w_sub_p1     = sub_word(r_data_p1);
`endif

    // Stage 1: capture the accepted beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1  <= 1'b0;
            r_data_p1 <= '0;
`ifdef SBOX_INV_EN
            r_inv_p1  <= 1'b0;
`endif
        end else if (w_in_xfer) begin
            r_vld_p1  <= 1'b1;
            r_data_p1 <= bus.in_data;
`ifdef SBOX_INV_EN
            r_inv_p1  <= bus.in_inv;
`endif
        end else if (w_adv_p2) begin
            r_vld_p1  <= 1'b0;
        end
    end

    // Stage 2: register the lookup result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p2  <= 1'b0;
            r_data_p2 <= '0;
        end else if (w_adv_p2) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_data_p2 <= w_sub_p1;
            end
        end
    end

    assign bus.in_ready  = w_in_rdy;
    assign bus.out_valid = r_vld_p2;
    assign bus.out_data  = r_data_p2;
    assign bus.busy      = r_vld_p1 || r_vld_p2;
endmodule

// File: tb/tb_sbox_stream.sv
// Scoreboard bench for sbox_stream: LANES=4 instance for handshake and streaming, LANES=16 for wide lanes.
// Reference tables are computed from GF(2^8) inversion plus the AES affine map.
module tb_sbox_stream;
    localparam int W = 32;
`ifdef SBOX_INV_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sbox_stream_if #(.LANES(4))  bus4 ();
    sbox_stream_if #(.LANES(16)) bus16 ();

    sbox_stream #(.LANES(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));
    sbox_stream #(.LANES(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

    int n_chk = 0;
    int n_bad = 0;
    logic [7:0] ref_fwd [256];
    logic [7:0] ref_inv [256];
    logic [W-1:0] exp_q [$];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        logic hi;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    task automatic build_ref();
        logic [7:0] x, inv, s;
        for (int v = 0; v < 256; v++) begin
            x = 8'(v);
            inv = 8'h00;
            if (x != 8'h00) begin
                inv = 8'h01;
                for (int k = 0; k < 254; k++) inv = gmul(inv, x);
            end
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            ref_fwd[v] = s;
            ref_inv[s] = x;
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] d, input logic inv, input int lanes);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < lanes; i++) begin
            r[8*i +: 8] = (inv && INV_EN) ? ref_inv[d[8*i +: 8]] : ref_fwd[d[8*i +: 8]];
        end
        return r;
    endfunction

    task automatic step(input logic iv, input logic [W-1:0] d, input logic inv,
                        input logic ordy, output logic acc);
        logic [W-1:0] e;
        logic [127:0] m;
        @(negedge clk);
        bus4.in_valid  = iv;
        bus4.in_data   = d;
        bus4.in_inv    = inv;
        bus4.out_ready = ordy;
        #1;
        if (bus4.out_valid && ordy) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", 128'(bus4.out_valid), 128'(1'b0));
            end else begin
                e = exp_q.pop_front();
                chk("out_data", 128'(bus4.out_data), 128'(e));
            end
        end
        acc = iv && bus4.in_ready;
        if (acc) begin
            m = model(128'(d), inv, 4);
            exp_q.push_back(m[W-1:0]);
        end
    endtask

    task automatic drain(input int budget);
        int k;
        logic a;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            step(1'b0, '0, 1'b0, 1'b1, a);
            k++;
        end
        chk("drain_left", 128'(exp_q.size()), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", n_chk, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic a;
        int k;
        bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.in_inv = 1'b0; bus4.out_ready = 1'b0;
        bus16.in_valid = 1'b0; bus16.in_data = '0; bus16.in_inv = 1'b0; bus16.out_ready = 1'b1;
        build_ref();

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 128'(bus4.out_valid), 128'(1'b0));
        chk("rst_busy", 128'(bus4.busy), 128'(1'b0));
        chk("rst_in_ready", 128'(bus4.in_ready), 128'(1'b1));
        chk("rst_out_data", 128'(bus4.out_data), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Single forward beat with latency check
        step(1'b1, 32'h01FF5300, 1'b0, 1'b1, a);
        chk("single_acc", 128'(a), 128'(1'b1));
        step(1'b0, '0, 1'b0, 1'b1, a);
        chk("single_early_valid", 128'(bus4.out_valid), 128'(1'b0));
        chk("single_busy", 128'(bus4.busy), 128'(1'b1));
        step(1'b0, '0, 1'b0, 1'b1, a);
        chk("single_valid", 128'(bus4.out_valid), 128'(1'b1));
        chk("single_vec", 128'(bus4.out_data), 128'(32'h7C16ED63));
        step(1'b0, '0, 1'b0, 1'b1, a);
        chk("single_valid_once", 128'(bus4.out_valid), 128'(1'b0));
        chk("single_idle", 128'(bus4.busy), 128'(1'b0));

        // Inverse-mode beat
        step(1'b1, 32'h7C16ED63, 1'b1, 1'b1, a);
        step(1'b0, '0, 1'b0, 1'b1, a);
        step(1'b0, '0, 1'b0, 1'b1, a);
`ifdef SBOX_INV_EN
        chk("inv_vec", 128'(bus4.out_data), 128'(32'h01FF5300));
`endif
        drain(8);

        // Back-pressure: two beats fit, third waits
        step(1'b1, 32'h00000000, 1'b0, 1'b0, a);
        chk("bp_acc0", 128'(a), 128'(1'b1));
        step(1'b1, 32'h11111111, 1'b0, 1'b0, a);
        chk("bp_acc1", 128'(a), 128'(1'b1));
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'h22222222, 1'b0, 1'b0, a);
            chk("bp_reject", 128'(a), 128'(1'b0));
            chk("bp_hold", 128'(bus4.out_data), 128'(32'h63636363));
        end
        step(1'b1, 32'h22222222, 1'b0, 1'b1, a);
        chk("bp_resume_acc", 128'(a), 128'(1'b1));
        drain(10);

        // Streaming with random back-pressure and alternating mode
        for (int i = 0; i < 256; i++) begin
            k = 0;
            do begin
                step(1'b1, {4{8'(i)}}, i[0], 1'($urandom_range(0, 1)), a);
                k++;
            end while (!a && k < 64);
            if (!a) chk("stream_accept", 128'(a), 128'(1'b1));
        end
        drain(600);

        // Reset with two beats in flight; inputs during reset are ignored
        step(1'b1, 32'hA5A5A5A5, 1'b0, 1'b0, a);
        step(1'b1, 32'h3C3C3C3C, 1'b1, 1'b0, a);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 128'(bus4.out_valid), 128'(1'b0));
        chk("mid_rst_busy", 128'(bus4.busy), 128'(1'b0));
        chk("mid_rst_data", 128'(bus4.out_data), 128'(0));
        chk("mid_rst_ready", 128'(bus4.in_ready), 128'(1'b1));
        exp_q.delete();
        bus4.in_data = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        chk("rst_ignores_in", 128'(bus4.busy), 128'(1'b0));
        @(negedge clk);
        bus4.in_valid = 1'b0;
        rst_n = 1'b1;
        step(1'b1, 32'h53535353, 1'b0, 1'b1, a);
        step(1'b0, '0, 1'b0, 1'b1, a);
        chk("post_rst_early", 128'(bus4.out_valid), 128'(1'b0));
        step(1'b0, '0, 1'b0, 1'b1, a);
        chk("post_rst_valid", 128'(bus4.out_valid), 128'(1'b1));
        chk("post_rst_vec", 128'(bus4.out_data), 128'(32'hEDEDEDED));
        drain(8);

        // Sixteen-lane instance
        @(negedge clk);
        bus16.in_valid = 1'b1;
        bus16.in_data  = 128'h0F0E0D0C0B0A09080706050403020100;
        bus16.in_inv   = 1'b0;
        #1;
        chk("l16_ready", 128'(bus16.in_ready), 128'(1'b1));
        @(negedge clk);
        bus16.in_valid = 1'b0;
        k = 0;
        #1;
        while (!bus16.out_valid && k < 8) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("l16_valid", 128'(bus16.out_valid), 128'(1'b1));
        chk("l16_vec", bus16.out_data, 128'h76ABD7FE2B670130C56F6BF27B777C63);
        chk("l16_model", bus16.out_data, model(128'h0F0E0D0C0B0A09080706050403020100, 1'b0, 16));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
